// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - register map, frame constants and FSM states for the SPI config slave
package spi_pkg;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;
  // One past a full frame; the counter parks here so long frames stay invalid.
  localparam logic [CNT_W-1:0] CNT_OVF = 5'd17;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage synchronizer for one async pin with rise/fall pulses
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - oversampled SPI mode-0 write-only slave driving the PWM config registers
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  logic sclk_level, sclk_rise, sclk_fall;
  logic copi_level, copi_rise, copi_fall;
  logic ncs_level, ncs_rise, ncs_fall;
  logic unused_edges;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .din(copi),
    .level(copi_level), .rise(copi_rise), .fall(copi_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .din(ncs),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );

  assign unused_edges = ^{sclk_level, sclk_fall, copi_rise, copi_fall};

  spi_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [15:0]      shift_q;
  logic             frame_start, commit, frame_ok, wr_en;
  logic [6:0]       addr;
  logic [7:0]       data;

  assign addr     = shift_q[14:8];
  assign data     = shift_q[7:0];
  assign frame_ok = (count_q == CNT_W'(FRAME_BITS)) && shift_q[15] && (int'(addr) <= MAX_ADDR);
  assign wr_en    = commit && frame_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A low select level (not just the fall pulse) starts a frame, so a fall
  // that lands while COMMIT is still busy is picked up once back in IDLE.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    commit      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ncs_fall || !ncs_level) begin
          state_d     = SHIFT;
          frame_start = 1'b1;
        end
      end
      SHIFT:   if (ncs_rise) state_d = COMMIT;
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q         <= '0;
      shift_q         <= '0;
      wr_strobe       <= 1'b0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      wr_strobe <= wr_en;
      if (frame_start) begin
        count_q <= '0;
        shift_q <= '0;
      end else if (state_q == SHIFT && sclk_rise && !ncs_level) begin
        shift_q <= {shift_q[14:0], copi_level};
        if (count_q != CNT_OVF) count_q <= count_q + 5'd1;
      end
      if (wr_en) begin
        case (addr)
          ADDR_EN_OUT_7_0:  en_reg_out_7_0  <= data;
          ADDR_EN_OUT_15_8: en_reg_out_15_8 <= data;
          ADDR_EN_PWM_7_0:  en_reg_pwm_7_0  <= data;
          ADDR_EN_PWM_15_8: en_reg_pwm_15_8 <= data;
          ADDR_PWM_DUTY:    pwm_duty_cycle  <= data;
          default: ;
        endcase
      end
    end
  end

endmodule
